// File: rtl/mips_defs.sv
// Shared MIPS multicycle definitions: opcode/funct values, ALU codes, FSM states and datapath mux selects.
package mips_defs;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  // ALU operation class requested by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU control decoder: maps the FSM's ALU op class plus the R-type funct field to a 3-bit ALU code.
module mips_alu_decoder
  import mips_defs::*;
(
  input  logic [1:0]       i_alu_op,
  input  logic [FN_W-1:0]  i_funct,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic             o_funct_valid
);

  logic [ALU_W-1:0] w_fn_ctrl;

  always_comb begin
    w_fn_ctrl     = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_funct)
      FN_ADD:  w_fn_ctrl = ALU_ADD;
      FN_SUB:  w_fn_ctrl = ALU_SUB;
      FN_AND:  w_fn_ctrl = ALU_AND;
      FN_OR:   w_fn_ctrl = ALU_OR;
      FN_SLT:  w_fn_ctrl = ALU_SLT;
      default: o_funct_valid = 1'b0;
    endcase

    // Unknown funct keeps ADD so the ALU never sees an undefined code
    case (i_alu_op)
      ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: o_alu_ctrl = w_fn_ctrl;
      default:     o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode, execute, memory and writeback steps.
module mips_mc_control
  import mips_defs::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FN_W-1:0]    funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       w_alu_op;
  logic [ALU_W-1:0] w_dec_ctrl;
  logic             w_funct_valid;
  logic             w_pc_write;
  logic             w_branch;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_write;
  logic             w_illegal;

  mips_alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct       (funct),
    .o_alu_ctrl    (w_dec_ctrl),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_alu_op = ALUOP_ADD;
    if (r_state == S_EXECUTE)     w_alu_op = ALUOP_FUNCT;
    else if (r_state == S_BRANCH) w_alu_op = ALUOP_SUB;
  end

  always_comb begin
    w_next      = S_FETCH;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    pc_src      = PCSRC_ALU;
    alu_ctrl    = ALU_ADD;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        alu_src_b  = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_funct_valid) w_next = S_EXECUTE;
            else               w_illegal = 1'b1;
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = w_dec_ctrl;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = w_dec_ctrl;
        w_branch  = 1'b1;
        pc_src    = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      // Unreachable encodings look like FETCH with every strobe quiet
      default: alu_src_b = SRCB_FOUR;
    endcase
  end

  // Strobes are held off for the whole reset window so no aborted write can land
  assign pc_en      = (w_pc_write | (w_branch & zero)) & ~rst;
  assign mem_write  = w_mem_write & ~rst;
  assign ir_write   = w_ir_write & ~rst;
  assign reg_write  = w_reg_write & ~rst;
  assign illegal_op = w_illegal & ~rst;
  assign state_o    = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-instruction behaviour summaries against an instruction-level model.
module tb_mips_mc_control;
  import mips_defs::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_mc_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctrl(alu_ctrl), .illegal_op(illegal_op), .state_o(state_o)
  );

  // What one instruction does, seen from outside: cycle indices are 1-based from its fetch cycle
  typedef struct {
    int cycles;
    int wr_cnt;
    int wr_cycle;
    int wr_dst;
    int wr_m2r;
    int memw_cnt;
    int memw_cycle;
    int ill_cycle;
    int pcen_cnt;
    int late_pcsrc;
    int exec_ctrl;
  } summ_t;

  summ_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;

  function automatic summ_t blank();
    summ_t s;
    s.cycles = 0;     s.wr_cnt = 0;      s.wr_cycle = -1;  s.wr_dst = -1;
    s.wr_m2r = -1;    s.memw_cnt = 0;    s.memw_cycle = -1; s.ill_cycle = -1;
    s.pcen_cnt = 0;   s.late_pcsrc = -1; s.exec_ctrl = -1;
    return s;
  endfunction

  task automatic cmp(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  // Instruction-level reference: latency table, which writes happen when, and ALU code for R/beq
  function automatic summ_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    summ_t s = blank();
    s.pcen_cnt = 1;
    case (op)
      6'b100011: begin s.cycles = 5; s.wr_cnt = 1; s.wr_cycle = 5; s.wr_dst = 0; s.wr_m2r = 1; end
      6'b101011: begin s.cycles = 4; s.memw_cnt = 1; s.memw_cycle = 4; end
      6'b000000: begin
        case (fn)
          6'b100000: s.exec_ctrl = 2;
          6'b100010: s.exec_ctrl = 6;
          6'b100100: s.exec_ctrl = 0;
          6'b100101: s.exec_ctrl = 1;
          6'b101010: s.exec_ctrl = 7;
          default:   s.exec_ctrl = -1;
        endcase
        if (s.exec_ctrl >= 0) begin
          s.cycles = 4; s.wr_cnt = 1; s.wr_cycle = 4; s.wr_dst = 1; s.wr_m2r = 0;
        end else begin
          s.cycles = 2; s.ill_cycle = 2;
        end
      end
      6'b000100: begin
        s.cycles = 3; s.exec_ctrl = 6;
        if (z) begin s.pcen_cnt = 2; s.late_pcsrc = 1; end
      end
      6'b001000: begin s.cycles = 4; s.wr_cnt = 1; s.wr_cycle = 4; s.wr_dst = 0; s.wr_m2r = 0; end
      6'b000010: begin s.cycles = 3; s.pcen_cnt = 2; s.late_pcsrc = 2; end
      default:   begin s.cycles = 2; s.ill_cycle = 2; end
    endcase
    return s;
  endfunction

  summ_t cur;
  bit    seg_open = 1'b0;

  task automatic close_seg();
    summ_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_instr got=%0d want=0 at %0t", cur.cycles, $time);
    end else begin
      e = exp_q.pop_front();
      cmp("cycles",     cur.cycles,     e.cycles);
      cmp("wr_cnt",     cur.wr_cnt,     e.wr_cnt);
      cmp("wr_cycle",   cur.wr_cycle,   e.wr_cycle);
      cmp("wr_dst",     cur.wr_dst,     e.wr_dst);
      cmp("wr_m2r",     cur.wr_m2r,     e.wr_m2r);
      cmp("memw_cnt",   cur.memw_cnt,   e.memw_cnt);
      cmp("memw_cycle", cur.memw_cycle, e.memw_cycle);
      cmp("ill_cycle",  cur.ill_cycle,  e.ill_cycle);
      cmp("pcen_cnt",   cur.pcen_cnt,   e.pcen_cnt);
      cmp("late_pcsrc", cur.late_pcsrc, e.late_pcsrc);
      cmp("exec_ctrl",  cur.exec_ctrl,  e.exec_ctrl);
    end
  endtask

  // Monitor: segments the output stream at each IR load and summarises each instruction
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ir_write) begin
        if (seg_open) close_seg();
        cur = blank();
        seg_open = 1'b1;
        cmp("fetch_iord", int'(iord), 0);
        cmp("fetch_srcb", int'(alu_src_b), 1);
        cmp("fetch_pcsrc", int'(pc_src), 0);
      end
      if (seg_open) begin
        cur.cycles++;
        if (reg_write) begin
          cur.wr_cnt++; cur.wr_cycle = cur.cycles;
          cur.wr_dst = reg_dst ? 1 : 0; cur.wr_m2r = mem_to_reg ? 1 : 0;
        end
        if (mem_write) begin cur.memw_cnt++; cur.memw_cycle = cur.cycles; end
        if (illegal_op) cur.ill_cycle = cur.cycles;
        if (pc_en) begin
          cur.pcen_cnt++;
          if (cur.cycles > 1) cur.late_pcsrc = int'(pc_src);
        end
        if (alu_src_a && alu_src_b == 2'b00) cur.exec_ctrl = int'(alu_ctrl);
      end
      cmp("alu_ctrl_legal",
          (alu_ctrl == 3'b011 || alu_ctrl == 3'b100 || alu_ctrl == 3'b101) ? 0 : 1, 1);
    end
  end

  // Called one step after the clock edge that enters DECODE; returns at the next such point
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    summ_t e;
    e = model(op, fn, z);
    opcode = op; funct = fn; zero = z;
    exp_q.push_back(e);
    repeat (e.cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=0 want=1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns [5];
    int         k;
    int         budget;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_state", int'(state_o), int'(S_FETCH));
    cmp("rst_strobes", int'({pc_en, mem_write, ir_write, reg_write, illegal_op}), 0);
    cmp("rst_srcb", int'(alu_src_b), 1);

    // Reset in the middle of a lw
    opcode = 6'b100011; funct = 6'd0;
    rst = 1'b0;
    @(negedge clk);
    cmp("rel_ir_write", int'(ir_write), 1);
    repeat (3) @(posedge clk);
    #1;
    cmp("memrd_iord", int'(iord), 1);
    rst = 1'b1;
    #1;
    cmp("midlw_state", int'(state_o), int'(S_FETCH));
    cmp("midlw_strobes", int'({pc_en, mem_write, ir_write, reg_write, illegal_op}), 0);
    @(posedge clk);
    #1;
    cmp("midlw_strobes2", int'({pc_en, mem_write, ir_write, reg_write, illegal_op}), 0);
    rst = 1'b0;
    @(negedge clk);
    cmp("rel2_ir_write", int'(ir_write), 1);
    cmp("rel2_pc_en", int'(pc_en), 1);
    cmp("rel2_state", int'(state_o), int'(S_FETCH));

    // Reset while a store strobe is up
    @(posedge clk); #1;
    opcode = 6'b101011;
    repeat (2) @(posedge clk);
    #1;
    cmp("memwr_strobe", int'(mem_write), 1);
    rst = 1'b1;
    #1;
    cmp("memwr_abort", int'(mem_write), 0);
    cmp("memwr_abort_state", int'(state_o), int'(S_FETCH));
    @(posedge clk); #1;

    // Scoreboarded instruction stream
    mon_en = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(6'b100011, 6'd0, 1'b0);
    issue(6'b000000, 6'b101010, 1'b0);
    issue(6'b000100, 6'd0, 1'b1);
    issue(6'b000100, 6'd0, 1'b0);
    issue(6'b111111, 6'd0, 1'b0);
    issue(6'b000000, 6'b000000, 1'b0);
    issue(6'b001000, 6'd0, 1'b0);
    issue(6'b000010, 6'd0, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0:       issue(6'b100011, 6'($urandom), 1'($urandom));
        1:       issue(6'b101011, 6'($urandom), 1'($urandom));
        2:       issue(6'b000100, 6'($urandom), 1'($urandom));
        3:       issue(6'b001000, 6'($urandom), 1'($urandom));
        4:       issue(6'b000010, 6'($urandom), 1'($urandom));
        default: issue(6'b000000, fns[k-5], 1'($urandom));
      endcase
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    cmp("queue_drain", exp_q.size(), 0);
    @(posedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
